bus_requester: RTL

BUS_REQUESTER -- requirements
Module: bus_requester

---
 rtl/bus_requester_pkg.sv | 15 +
 rtl/bus_requester_req_fifo.sv | 58 +++++
 rtl/bus_requester.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_requester_pkg.sv
// rtl/bus_requester_pkg.sv - shared constants and FSM state type for the bus requester
package bus_requester_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_STARVE_LIM = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/bus_requester_req_fifo.sv
// rtl/bus_requester_req_fifo.sv - pending-transfer queue of {addr,data} entries
module req_fifo
  import bus_requester_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [ADDR_W+DATA_W-1:0] head;

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a push into a full queue overwrites the head slot being popped this cycle
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  assign full = (count == CNT_FULL);
  assign head = (count != '0) ? mem[rd_ptr] : '0;
  assign {head_addr, head_data} = head;

endmodule

// File: rtl/bus_requester.sv
// rtl/bus_requester.sv - queued bus requester with round-robin request line and starve flag
module bus_requester
  import bus_requester_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              REQ,
  input  logic              GNT,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              starve,
  output logic [1:0]        state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIM);

  logic [CW-1:0]     count;
  logic [CW-1:0]     next_count;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  state_t            cur_state;
  state_t            nxt_state;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_nxt;

  // A grant on an empty queue is ignored; a pop frees a slot so a push can land even when full
  assign pop        = GNT & (count != '0);
  assign push       = wr_en & (~full | pop);
  assign next_count = count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

  req_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // FSM next state from the occupancy and grant seen this cycle
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (push) nxt_state = WAIT;
      WAIT:    if (next_count == '0) nxt_state = IDLE;
               else if (pop)         nxt_state = XFER;
      XFER:    if (next_count == '0) nxt_state = IDLE;
               else if (pop)         nxt_state = XFER;
               else                  nxt_state = WAIT;
      default: nxt_state = IDLE;
    endcase
  end

  // FSM outputs: request looks ahead so the registered arbiter only grants real entries
  always_comb begin
    REQ       = (next_count != '0);
    bus_valid = pop;
    bus_addr  = head_addr;
    bus_data  = head_data;
  end

  assign state = cur_state;

  // Ungranted-wait counter: clears on any grant, saturates at the starve limit
  always_comb begin
    wait_nxt = wait_cnt;
    if (GNT)                            wait_nxt = '0;
    else if (REQ && wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WAIT_ONE;
  end

  // Wait counter and sticky starve flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX) starve <= 1'b1;
    end
  end

endmodule
